// File: rtl/mod4051_pkg.sv
// Shared constants, FSM state type and chunk weight helper
// for the mod-4051 chunked reduction controller.
package mod4051_pkg;

    localparam int DEF_MOD     = 4051;
    localparam int DEF_CHUNK_W = 6;
    localparam int DEF_NCHUNK  = 6;
    localparam int DEF_RES_W   = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // (2^cw)^i mod m, evaluated at elaboration to build the weight table
    function automatic int chunk_weight(input int i, input int cw, input int m);
        int w;
        w = 1 % m;
        for (int k = 0; k < 8; k++) begin
            if (k < i) w = (w << cw) % m;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod4051_chunk_lut.sv
// Combinational chunk residue: chunk * 64^idx mod MOD.
// Weights are elaboration-time constants; only the product is reduced.
module mod4051_chunk_lut
    import mod4051_pkg::*;
#(
    parameter int MOD     = DEF_MOD,
    parameter int CHUNK_W = DEF_CHUNK_W,
    parameter int RES_W   = DEF_RES_W
) (
    input  logic [2:0]         idx,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [RES_W-1:0]   res
);

    logic [RES_W-1:0]         wtab [8];
    logic [RES_W-1:0]         w;
    logic [CHUNK_W+RES_W-1:0] prod;

    for (genvar g = 0; g < 8; g++) begin : g_wtab
        assign wtab[g] = RES_W'(chunk_weight(g, CHUNK_W, MOD));
    end

    assign w    = wtab[idx];
    assign prod = chunk * w;
    assign res  = RES_W'(int'(prod) % MOD);

endmodule

// File: rtl/mod4051_reduce_ctrl.sv
// Sequential X mod 4051 reducer: one 6-bit chunk per cycle through
// a residue LUT and a single conditional-subtract modular adder.
module mod4051_reduce_ctrl
    import mod4051_pkg::*;
#(
    parameter int MOD     = DEF_MOD,
    parameter int CHUNK_W = DEF_CHUNK_W,
    parameter int NCHUNK  = DEF_NCHUNK,
    parameter int RES_W   = DEF_RES_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHUNK_W*NCHUNK-1:0] in_data,
    input  logic                      clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RES_W-1:0]          out_data,
    output logic                      busy
);

    localparam int             OP_W = CHUNK_W * NCHUNK;
    localparam logic [2:0]     LAST = 3'(NCHUNK - 1);
    localparam logic [RES_W:0] MODW = (RES_W + 1)'(MOD);

    state_t             state;
    logic [OP_W-1:0]    opnd;
    logic [2:0]         idx;
    logic [RES_W-1:0]   acc;
    logic [CHUNK_W-1:0] chunk;
    logic [RES_W-1:0]   lut;
    logic [RES_W:0]     sum;
    logic [RES_W-1:0]   red;

    assign chunk = opnd[32'(idx) * CHUNK_W +: CHUNK_W];

    mod4051_chunk_lut #(
        .MOD     (MOD),
        .CHUNK_W (CHUNK_W),
        .RES_W   (RES_W)
    ) u_lut (
        .idx   (idx),
        .chunk (chunk),
        .res   (lut)
    );

    // Both operands are < MOD, so one conditional subtract suffices
    assign sum = {1'b0, acc} + {1'b0, lut};
    assign red = (sum >= MODW) ? RES_W'(sum - MODW) : sum[RES_W-1:0];

    assign out_data = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            opnd      <= '0;
            idx       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (clr) begin
            state     <= S_IDLE;
            idx       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opnd     <= in_data;
                        idx      <= '0;
                        acc      <= '0;
                        state    <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc <= red;
                    idx <= idx + 3'd1;
                    if (idx == LAST) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod4051_reduce_ctrl.sv
// Scoreboard bench for mod4051_reduce_ctrl: directed vectors plus
// random operands checked against a direct X mod 4051 reference.
module tb_mod4051_reduce_ctrl;

    typedef struct {
        logic [11:0] v;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [35:0] in_data = '0;
    logic        clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_data;
    logic        busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic ov_q = 1'b0;

    mod4051_reduce_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer x when the DUT is idle; optionally push the expected result
    task automatic send(input logic [35:0] x, input bit push, input logic [11:0] exp);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{exp, cyc});
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_q = 1'b0;
        end else begin
            if (out_valid && !ov_q) begin
                if (sb.size() == 0) check("spurious_valid", 1, 0);
                else check("latency", cyc - sb[0].c, 6);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                check("out_data", int'(out_data), int'(sb[0].v));
                void'(sb.pop_front());
            end
            ov_q = out_valid;
        end
    end

    initial begin
        logic [35:0] x;
        bit   [31:0] lo;
        bit   [3:0]  hi;

        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;

        send(36'd0, 1'b1, 12'd0);
        send(36'd4051, 1'b1, 12'd0);
        send(36'd4050, 1'b1, 12'd4050);
        send(36'd4096, 1'b1, 12'd45);
        send(36'd4052, 1'b1, 12'd1);
        send(36'd64, 1'b1, 12'd64);
        drain();

        // Back-pressure: result must hold while out_ready is low
        out_ready = 1'b0;
        send(36'hF_FFFF_FFFF, 1'b1, 12'd2002);
        @(negedge clk);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), 2002);
            check("stall_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // Abort with clr while idx == 3
        send(36'h1_2345_6789, 1'b0, 12'd0);
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("clr_busy", int'(busy), 0);
        check("clr_in_ready", int'(in_ready), 1);
        check("clr_out_valid", int'(out_valid), 0);
        repeat (8) @(negedge clk);
        send(36'd4096, 1'b1, 12'd45);
        drain();

        // Asynchronous reset in the middle of RUN
        send(36'h9_8765_4321, 1'b0, 12'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_out_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", int'(in_ready), 1);
        repeat (10) @(negedge clk);
        check("arst_no_valid", int'(out_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            lo = $urandom;
            hi = 4'($urandom);
            x  = {hi, lo};
            send(x, 1'b1, 12'(64'(x) % 64'd4051));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
